// File: rtl/gray_hist_eq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_hist_eq : per-frame 256-bin histogram -> cumulative LUT -> remap    |
// | Optional iBypass port enabled by `define HISTEQ_BYPASS_EN                 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module gray_hist_eq #(
    parameter int FRAME_PIX = 384000,
    parameter int CNT_W     = 19,
    parameter int RECIP     = 11141,
    parameter int RECIP_W   = 16
) (
    input  logic       iCLK,
    input  logic       iReset_n,
    input  logic [7:0] iGray,
    input  logic       iDval,
    input  logic       iFval,
`ifdef HISTEQ_BYPASS_EN
    input  logic       iBypass,
`endif
    output logic [7:0] oGray,
    output logic       oDval,
    output logic       oLutValid,
    output logic       oBusy
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_CDF   = 2'd3;

    localparam int PROD_W = CNT_W + RECIP_W;
    localparam int RND_W  = PROD_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((64'd1 << CNT_W) <= 64'(FRAME_PIX)) begin : g_cnt_w_check
        $error("gray_hist_eq: CNT_W too narrow for FRAME_PIX");
    end

    logic [CNT_W-1:0] hist_mem  [256];
    logic [7:0]       lut_a_mem [256];
    logic [7:0]       lut_b_mem [256];

    logic [1:0]       state_q, state_d;
    logic [7:0]       init_cnt_q, init_cnt_d;
    logic [8:0]       cdf_cnt_q, cdf_cnt_d;
    logic [CNT_W-1:0] sum_q, sum_d;
    logic             fval_q, fval_d;
    logic             s1_vld_q, s1_vld_d;
    logic [7:0]       s1_addr_q, s1_addr_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic             wr_vld_q, wr_vld_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0] wr_data_q, wr_data_d;
    logic             bank_sel_q, bank_sel_d;
    logic             lut_valid_q, lut_valid_d;
    logic [7:0]       gray_q, gray_d;
    logic             dval_q, dval_d;

    logic             w_rise, w_fall, w_count;
    logic [7:0]       w_rd_addr;
    logic [CNT_W-1:0] w_cur, w_inc;
    logic [CNT_W:0]   w_sum_add;
    logic [CNT_W-1:0] w_sum_new;
    logic [PROD_W-1:0] w_prod;
    logic [RND_W-1:0] w_rnd, w_scaled;
    logic [7:0]       w_lut_val, w_lut_rd;
    logic             hist_we, lut_we;
    logic [7:0]       hist_waddr, lut_waddr;
    logic [CNT_W-1:0] hist_wdata;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        cdf_cnt_d   = cdf_cnt_q;
        sum_d       = sum_q;
        bank_sel_d  = bank_sel_q;
        lut_valid_d = lut_valid_q;
        hist_we     = 1'b0;
        hist_waddr  = 8'd0;
        hist_wdata  = '0;
        lut_we      = 1'b0;
        lut_waddr   = cdf_cnt_q[7:0] - 8'd1;

        fval_d  = iFval;
        w_rise  = iFval & ~fval_q;
        w_fall  = ~iFval & fval_q;
        w_count = iDval & iFval &
                  ((state_q == ST_ACCUM) | ((state_q == ST_IDLE) & w_rise));

        // Stage 1 captures the bin and its registered read; stage 2 writes back.
        s1_vld_d  = w_count;
        s1_addr_d = iGray;
        w_rd_addr = (state_q == ST_CDF) ? cdf_cnt_q[7:0] : iGray;
        rd_d      = hist_mem[w_rd_addr];

        // The read was taken before the previous write landed; forward it.
        w_cur     = (wr_vld_q && (wr_addr_q == s1_addr_q)) ? wr_data_q : rd_q;
        w_inc     = (w_cur == CNT_MAX) ? w_cur : w_cur + 1'b1;
        wr_vld_d  = s1_vld_q;
        wr_addr_d = s1_addr_q;
        wr_data_d = w_inc;

        w_sum_add = {1'b0, sum_q} + {1'b0, rd_q};
        w_sum_new = w_sum_add[CNT_W] ? CNT_MAX : w_sum_add[CNT_W-1:0];
        w_prod    = PROD_W'(w_sum_new) * PROD_W'(RECIP);
        w_rnd     = {1'b0, w_prod} + RND_W'(24'h80_0000);
        w_scaled  = w_rnd >> 24;
        w_lut_val = (w_scaled > RND_W'(255)) ? 8'hFF : w_scaled[7:0];

        case (state_q)
            ST_INIT: begin
                hist_we    = 1'b1;
                hist_waddr = init_cnt_q;
                init_cnt_d = init_cnt_q + 8'd1;
                if (init_cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_fall) begin
                    state_d   = ST_CDF;
                    cdf_cnt_d = 9'd0;
                    sum_d     = '0;
                end
            end
            ST_CDF: begin
                cdf_cnt_d = cdf_cnt_q + 9'd1;
                // Count n reads bin n and retires bin n-1 from the registered read.
                if (cdf_cnt_q != 9'd0) begin
                    sum_d      = w_sum_new;
                    lut_we     = 1'b1;
                    hist_we    = 1'b1;
                    hist_waddr = lut_waddr;
                end
                if (cdf_cnt_q == 9'd256) begin
                    state_d     = ST_IDLE;
                    bank_sel_d  = ~bank_sel_q;
                    lut_valid_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (s1_vld_q) begin
            hist_we    = 1'b1;
            hist_waddr = s1_addr_q;
            hist_wdata = w_inc;
        end

        w_lut_rd = bank_sel_q ? lut_b_mem[iGray] : lut_a_mem[iGray];
        gray_d   = lut_valid_q ? w_lut_rd : iGray;
`ifdef HISTEQ_BYPASS_EN
        if (iBypass) begin
            gray_d = iGray;
        end
`endif
        dval_d = iDval;
    end

    always_ff @(posedge iCLK) begin
        if (!iReset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 8'd0;
            cdf_cnt_q   <= 9'd0;
            sum_q       <= '0;
            fval_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= 8'd0;
            rd_q        <= '0;
            wr_vld_q    <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= '0;
            bank_sel_q  <= 1'b0;
            lut_valid_q <= 1'b0;
            gray_q      <= 8'd0;
            dval_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cdf_cnt_q   <= cdf_cnt_d;
            sum_q       <= sum_d;
            fval_q      <= fval_d;
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            rd_q        <= rd_d;
            wr_vld_q    <= wr_vld_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bank_sel_q  <= bank_sel_d;
            lut_valid_q <= lut_valid_d;
            gray_q      <= gray_d;
            dval_q      <= dval_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (hist_we) begin
            hist_mem[hist_waddr] <= hist_wdata;
        end
        if (lut_we && !bank_sel_q) begin
            lut_b_mem[lut_waddr] <= w_lut_val;
        end
        if (lut_we && bank_sel_q) begin
            lut_a_mem[lut_waddr] <= w_lut_val;
        end
    end

    assign oGray     = gray_q;
    assign oDval     = dval_q;
    assign oLutValid = lut_valid_q;
    assign oBusy     = (state_q == ST_INIT) | (state_q == ST_CDF);

endmodule
`default_nettype wire

// File: tb/tb_gray_hist_eq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_hist_eq : directed self-checking bench for gray_hist_eq          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gray_hist_eq;

    // Small frame so a full frame fits a short run: 2560 px, RECIP = 255*2^24/2560.
    localparam int FP = 2560;
    localparam int CW = 12;
    localparam int RC = 1671168;
    localparam int RW = 21;

    logic       iCLK = 1'b0;
    logic       iReset_n;
    logic [7:0] iGray;
    logic       iDval;
    logic       iFval;
    logic [7:0] oGray;
    logic       oDval;
    logic       oLutValid;
    logic       oBusy;
`ifdef HISTEQ_BYPASS_EN
    logic       iBypass = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    gray_hist_eq #(
        .FRAME_PIX (FP),
        .CNT_W     (CW),
        .RECIP     (RC),
        .RECIP_W   (RW)
    ) dut (
        .iCLK      (iCLK),
        .iReset_n  (iReset_n),
        .iGray     (iGray),
        .iDval     (iDval),
        .iFval     (iFval),
`ifdef HISTEQ_BYPASS_EN
        .iBypass   (iBypass),
`endif
        .oGray     (oGray),
        .oDval     (oDval),
        .oLutValid (oLutValid),
        .oBusy     (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [7:0] v);
        iGray = v;
        iDval = 1'b1;
        step();
    endtask

    task automatic lut_chk(input string tag, input logic [7:0] k, input logic [7:0] exp);
        pix(k);
        chk(tag, 32'(oGray), 32'(exp));
        iDval = 1'b0;
    endtask

    task automatic open_frame();
        iFval = 1'b1;
        iDval = 1'b0;
        step();
    endtask

    task automatic close_frame();
        iDval = 1'b0;
        step();
        iFval = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (oBusy === 1'b1 && n < 400) begin
            step();
            n++;
        end
        // Publish must land within 3 pipeline cycles plus the 256-bin walk.
        chk(tag, 32'(n <= 259 && oBusy === 1'b0 && oLutValid === 1'b1), 32'd1);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (oBusy === 1'b1 && n < 300);
        chk(tag, 32'(n), 32'd256);
    endtask

    task automatic ramp_frame();
        open_frame();
        for (int v = 0; v < 256; v++) begin
            for (int r = 0; r < 10; r++) begin
                pix(8'(v));
            end
        end
        close_frame();
    endtask

    initial begin
        iReset_n = 1'b0;
        iGray    = 8'd0;
        iDval    = 1'b0;
        iFval    = 1'b0;
        step();
        step();
        chk("rst_ogray", 32'(oGray), 32'd0);
        chk("rst_odval", 32'(oDval), 32'd0);
        chk("rst_lutvalid", 32'(oLutValid), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd1);

        iReset_n = 1'b1;
        wait_init("init_cycles");

        iGray = 8'h5A;
        iDval = 1'b1;
        step();
        chk("pass_gray", 32'(oGray), 32'h5A);
        chk("pass_dval", 32'(oDval), 32'd1);
        iDval = 1'b0;
        step();
        chk("pass_dval_low", 32'(oDval), 32'd0);

        // Uniform frame: every pixel at 100, one unbroken run.
        open_frame();
        repeat (FP) pix(8'd100);
        close_frame();
        chk("cdf_busy", 32'(oBusy), 32'd1);
        wait_idle("uni_publish");
        lut_chk("uni_lut0", 8'd0, 8'd0);
        lut_chk("uni_lut99", 8'd99, 8'd0);
        lut_chk("uni_lut100", 8'd100, 8'd255);
        lut_chk("uni_lut200", 8'd200, 8'd255);
        repeat (20) step();

        // Ramp frame: 10 of each value; remapped through the uniform LUT meanwhile.
        open_frame();
        for (int v = 0; v < 256; v++) begin
            for (int r = 0; r < 10; r++) begin
                pix(8'(v));
                if (v == 50 && r == 0) chk("ramp_old_lut50", 32'(oGray), 32'd0);
                if (v == 150 && r == 0) chk("ramp_old_lut150", 32'(oGray), 32'd255);
            end
        end
        close_frame();
        wait_idle("ramp_publish");
        lut_chk("ramp_lut0", 8'd0, 8'd1);
        lut_chk("ramp_lut1", 8'd1, 8'd2);
        lut_chk("ramp_lut63", 8'd63, 8'd64);
        lut_chk("ramp_lut127", 8'd127, 8'd128);
        lut_chk("ramp_lut255", 8'd255, 8'd255);
        repeat (20) step();

        // Short blanking: next frame rises 100 cycles into the CDF walk.
        open_frame();
        repeat (FP) pix(8'd200);
        close_frame();
        repeat (100) step();
        chk("short_busy_at_rise", 32'(oBusy), 32'd1);
        open_frame();
        pix(8'd50);
        chk("excl_ramp_lut50", 32'(oGray), 32'd51);
        repeat (199) pix(8'd50);
        chk("excl_cdf_done", 32'(oBusy), 32'd0);
        pix(8'd50);
        chk("excl_new_lut50", 32'(oGray), 32'd0);
        close_frame();
        repeat (5) step();
        chk("excl_no_cdf", 32'(oBusy), 32'd0);
        lut_chk("f200_lut199", 8'd199, 8'd0);
        lut_chk("f200_lut200", 8'd200, 8'd255);
        repeat (20) step();

        // The excluded 50s must not have reached this frame's histogram.
        open_frame();
        repeat (FP) pix(8'd30);
        close_frame();
        wait_idle("f30_publish");
        lut_chk("f30_lut29", 8'd29, 8'd0);
        lut_chk("f30_lut30", 8'd30, 8'd255);
        lut_chk("f30_lut49", 8'd49, 8'd255);
        repeat (20) step();

        // Oversized frame: scaled CDF exceeds 255 and must clamp.
        open_frame();
        repeat (3000) pix(8'd0);
        close_frame();
        wait_idle("clamp_publish");
        lut_chk("clamp_lut0", 8'd0, 8'd255);
        repeat (20) step();

        // Reset in the middle of accumulation.
        open_frame();
        repeat (1000) pix(8'd77);
        iReset_n = 1'b0;
        iDval    = 1'b0;
        iFval    = 1'b0;
        step();
        step();
        chk("mid_rst_lutvalid", 32'(oLutValid), 32'd0);
        chk("mid_rst_busy", 32'(oBusy), 32'd1);
        chk("mid_rst_ogray", 32'(oGray), 32'd0);
        iReset_n = 1'b1;
        wait_init("init_cycles2");
        lut_chk("mid_rst_pass", 8'h33, 8'h33);
        repeat (5) step();
        ramp_frame();
        wait_idle("ramp2_publish");
        lut_chk("ramp2_lut0", 8'd0, 8'd1);
        lut_chk("ramp2_lut63", 8'd63, 8'd64);
        lut_chk("ramp2_lut127", 8'd127, 8'd128);
        lut_chk("ramp2_lut255", 8'd255, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
